// File: rtl/extmem_initiator_if.sv
// Request/response handshake and external memory port of the CPU-side memory initiator.
// The initiator uses the master view; the cache path and memory model use the slave view.
interface extmem_initiator_if #(
    parameter int ADRW = 13
);
    logic            req_valid;
    logic            req_ready;
    logic            req_rwb;
    logic            req_burst;
    logic [ADRW-1:0] req_adr;
    logic [31:0]     req_wdata;
    logic [3:0]      req_byteen;

    logic            rsp_valid;
    logic [31:0]     rsp_data;
    logic            rsp_last;
    logic            rsp_err;

    logic [ADRW-1:0] mem_adr;
    logic [31:0]     mem_wdata;
    logic            mem_oe;
    logic [31:0]     mem_rdata;
    logic [3:0]      mem_byteen;
    logic            mem_rwb;
    logic            mem_en;
    logic            mem_done;

    modport master (
        input  req_valid, req_rwb, req_burst, req_adr, req_wdata, req_byteen,
        output req_ready,
        output rsp_valid, rsp_data, rsp_last, rsp_err,
        output mem_adr, mem_wdata, mem_oe, mem_byteen, mem_rwb, mem_en,
        input  mem_rdata, mem_done
    );

    modport slave (
        output req_valid, req_rwb, req_burst, req_adr, req_wdata, req_byteen,
        input  req_ready,
        input  rsp_valid, rsp_data, rsp_last, rsp_err,
        input  mem_adr, mem_wdata, mem_oe, mem_byteen, mem_rwb, mem_en,
        output mem_rdata, mem_done
    );
endinterface

// File: rtl/extmem_initiator.sv
// CPU-side external memory bus master: single read/write and critical-word-first line
// fills, one response strobe per beat, timeout error path. All outputs are registered.
module extmem_initiator #(
    parameter int ADRW       = 13,
    parameter int LINE_WORDS = 4,
    parameter int TIMEOUT    = 255
)(
    input  logic                 ph1,
    input  logic                 reset,
    extmem_initiator_if.master   bus
);
    localparam int              LW2       = $clog2(LINE_WORDS);
    localparam logic [LW2-1:0]  LAST_BEAT = LW2'(LINE_WORDS - 1);
    localparam logic [7:0]      WAIT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RECOVER
    } state_t;

    state_t          r_state;
    logic            r_req_ready;
    logic            r_rwb;
    logic            r_burst;
    logic [ADRW-1:0] r_adr;
    logic [LW2-1:0]  r_beat;
    logic [7:0]      r_wait;

    logic            r_rsp_valid;
    logic [31:0]     r_rsp_data;
    logic            r_rsp_last;
    logic            r_rsp_err;

    logic [ADRW-1:0] r_mem_adr;
    logic [31:0]     r_mem_wdata;
    logic            r_mem_oe;
    logic [3:0]      r_mem_byteen;
    logic            r_mem_rwb;
    logic            r_mem_en;

    logic            w_last_beat;
    logic [LW2-1:0]  w_next_beat;

    // Wrap the beat offset inside the aligned line; upper address bits never change.
    function automatic logic [ADRW-1:0] f_beat_adr(input logic [ADRW-1:0] base,
                                                    input logic [LW2-1:0]  beat);
        logic [LW2-1:0] lo;
        lo = base[LW2-1:0] + beat;
        return {base[ADRW-1:LW2], lo};
    endfunction

    assign w_last_beat = !r_burst || (r_beat == LAST_BEAT);
    assign w_next_beat = r_beat + LW2'(1);

    always_ff @(posedge ph1) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b0;
            r_rwb        <= 1'b1;
            r_burst      <= 1'b0;
            r_adr        <= '0;
            r_beat       <= '0;
            r_wait       <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_last   <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_mem_adr    <= '0;
            r_mem_wdata  <= '0;
            r_mem_oe     <= 1'b0;
            r_mem_byteen <= '0;
            r_mem_rwb    <= 1'b1;
            r_mem_en     <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_last  <= 1'b0;
            r_rsp_err   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (bus.req_valid && r_req_ready) begin
                        r_state      <= S_ACCESS;
                        r_req_ready  <= 1'b0;
                        r_rwb        <= bus.req_rwb;
                        // Bursts are line fills; a burst write degrades to a single write.
                        r_burst      <= bus.req_burst && bus.req_rwb;
                        r_adr        <= bus.req_adr;
                        r_beat       <= '0;
                        r_wait       <= '0;
                        r_mem_en     <= 1'b1;
                        r_mem_adr    <= bus.req_adr;
                        r_mem_rwb    <= bus.req_rwb;
                        r_mem_oe     <= !bus.req_rwb;
                        r_mem_byteen <= bus.req_rwb ? 4'b0000 : bus.req_byteen;
                        r_mem_wdata  <= bus.req_rwb ? 32'd0 : bus.req_wdata;
                    end
                end

                S_ACCESS: begin
                    if (bus.mem_done) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= r_rwb ? bus.mem_rdata : 32'd0;
                        if (w_last_beat) begin
                            r_rsp_last   <= 1'b1;
                            r_state      <= S_RECOVER;
                            r_mem_en     <= 1'b0;
                            r_mem_oe     <= 1'b0;
                            r_mem_rwb    <= 1'b1;
                            r_mem_byteen <= 4'b0000;
                        end else begin
                            r_beat    <= w_next_beat;
                            r_wait    <= '0;
                            r_mem_adr <= f_beat_adr(r_adr, w_next_beat);
                        end
                    end else if (r_wait == WAIT_LAST) begin
                        // Done wins when it coincides with the final wait cycle.
                        r_rsp_valid  <= 1'b1;
                        r_rsp_err    <= 1'b1;
                        r_rsp_last   <= 1'b1;
                        r_state      <= S_RECOVER;
                        r_mem_en     <= 1'b0;
                        r_mem_oe     <= 1'b0;
                        r_mem_rwb    <= 1'b1;
                        r_mem_byteen <= 4'b0000;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end

                S_RECOVER: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b0;
                    r_mem_en    <= 1'b0;
                    r_mem_oe    <= 1'b0;
                    r_mem_rwb   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_data   = r_rsp_data;
    assign bus.rsp_last   = r_rsp_last;
    assign bus.rsp_err    = r_rsp_err;
    assign bus.mem_adr    = r_mem_adr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.mem_oe     = r_mem_oe;
    assign bus.mem_byteen = r_mem_byteen;
    assign bus.mem_rwb    = r_mem_rwb;
    assign bus.mem_en     = r_mem_en;
endmodule

// File: tb/tb_extmem_initiator.sv
// Directed bench for extmem_initiator: a vector table run with done tied high, plus
// hand-written wait-state, timeout, done-wins and mid-burst reset sequences.
module tb_extmem_initiator;
    logic        ph1;
    logic        reset;
    logic        r_done;
    logic [31:0] r_fixed;
    int          n_vec;
    int          n_err;

    extmem_initiator_if #(.ADRW(13)) bus();

    extmem_initiator #(.ADRW(13), .LINE_WORDS(4), .TIMEOUT(255)) dut (
        .ph1   (ph1),
        .reset (reset),
        .bus   (bus)
    );

    // Memory model: fixed word when requested, otherwise a pattern tagged with the address.
    assign bus.mem_rdata = (r_fixed != 32'd0) ? r_fixed : (32'hA5A5_0000 | 32'(bus.mem_adr));
    assign bus.mem_done  = r_done;

    initial begin
        ph1 = 1'b0;
        forever #5 ph1 = ~ph1;
    end

    typedef struct packed {
        logic             rwb;
        logic             burst;
        logic [12:0]      adr;
        logic [31:0]      wdata;
        logic [3:0]       byteen;
        logic [31:0]      fixed;
        logic [2:0]       nbeats;
        logic [3:0][12:0] exp_adr;
    } vec_t;

    vec_t vecs [7];

    function automatic vec_t mk(input logic rwb, input logic burst, input logic [12:0] adr,
                                input logic [31:0] wdata, input logic [3:0] byteen,
                                input logic [31:0] fixed, input logic [2:0] nbeats,
                                input logic [12:0] a0, input logic [12:0] a1,
                                input logic [12:0] a2, input logic [12:0] a3);
        vec_t v;
        v.rwb = rwb; v.burst = burst; v.adr = adr; v.wdata = wdata;
        v.byteen = byteen; v.fixed = fixed; v.nbeats = nbeats;
        v.exp_adr[0] = a0; v.exp_adr[1] = a1; v.exp_adr[2] = a2; v.exp_adr[3] = a3;
        return v;
    endfunction

    task automatic step();
        @(posedge ph1);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 20 && bus.req_ready !== 1'b1; k++) step();
        chk("req_ready", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic issue(input logic rwb, input logic burst, input logic [12:0] adr,
                         input logic [31:0] wdata, input logic [3:0] byteen);
        wait_ready();
        bus.req_valid  = 1'b1;
        bus.req_rwb    = rwb;
        bus.req_burst  = burst;
        bus.req_adr    = adr;
        bus.req_wdata  = wdata;
        bus.req_byteen = byteen;
        step();
        bus.req_valid  = 1'b0;
    endtask

    task automatic apply_vec(input int i);
        vec_t        v;
        logic [31:0] exp_d;
        v       = vecs[i];
        r_fixed = v.fixed;
        r_done  = 1'b1;
        issue(v.rwb, v.burst, v.adr, v.wdata, v.byteen);
        chk("ready_low_in_access", 32'(bus.req_ready), 32'd0);
        for (int b = 0; b < int'(v.nbeats); b++) begin
            chk("mem_en", 32'(bus.mem_en), 32'd1);
            chk("mem_adr", 32'(bus.mem_adr), 32'(v.exp_adr[b]));
            chk("mem_rwb", 32'(bus.mem_rwb), 32'(v.rwb));
            chk("mem_oe", 32'(bus.mem_oe), 32'(!v.rwb));
            chk("mem_byteen", 32'(bus.mem_byteen), v.rwb ? 32'd0 : 32'(v.byteen));
            if (!v.rwb) chk("mem_wdata", bus.mem_wdata, v.wdata);
            step();
            exp_d = !v.rwb ? 32'd0 :
                    (v.fixed != 32'd0) ? v.fixed : (32'hA5A5_0000 | 32'(v.exp_adr[b]));
            chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("rsp_data", bus.rsp_data, exp_d);
            chk("rsp_last", 32'(bus.rsp_last), 32'(b == int'(v.nbeats) - 1));
            chk("rsp_err", 32'(bus.rsp_err), 32'd0);
        end
        chk("recover_en", 32'(bus.mem_en), 32'd0);
        chk("recover_rwb", 32'(bus.mem_rwb), 32'd1);
        chk("recover_oe", 32'(bus.mem_oe), 32'd0);
        step();
        chk("idle_ready", 32'(bus.req_ready), 32'd1);
        chk("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        $display("txn vec %0d: rwb=%0b burst=%0b adr=%h beats=%0d", i, v.rwb, v.burst,
                 v.adr, v.nbeats);
    endtask

    initial begin
        logic bad;
        n_vec = 0;
        n_err = 0;
        vecs[0] = mk(1'b1, 1'b0, 13'h0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 3'd1,
                     13'h0010, 13'h0, 13'h0, 13'h0);
        vecs[1] = mk(1'b0, 1'b0, 13'h0004, 32'h1234_5678, 4'b0101, 32'h0, 3'd1,
                     13'h0004, 13'h0, 13'h0, 13'h0);
        vecs[2] = mk(1'b1, 1'b1, 13'h0102, 32'h0, 4'h0, 32'h0, 3'd4,
                     13'h0102, 13'h0103, 13'h0100, 13'h0101);
        vecs[3] = mk(1'b1, 1'b1, 13'h1FFF, 32'h0, 4'h0, 32'h0, 3'd4,
                     13'h1FFF, 13'h1FFC, 13'h1FFD, 13'h1FFE);
        vecs[4] = mk(1'b0, 1'b1, 13'h0100, 32'hCAFE_F00D, 4'b1111, 32'h0, 3'd1,
                     13'h0100, 13'h0, 13'h0, 13'h0);
        vecs[5] = mk(1'b1, 1'b1, 13'h0040, 32'h0, 4'h0, 32'h0, 3'd4,
                     13'h0040, 13'h0041, 13'h0042, 13'h0043);
        vecs[6] = mk(1'b1, 1'b0, 13'h1FFF, 32'h0, 4'h0, 32'h0, 3'd1,
                     13'h1FFF, 13'h0, 13'h0, 13'h0);

        reset = 1'b1;
        r_done = 1'b0;
        r_fixed = 32'd0;
        bus.req_valid = 1'b0;
        bus.req_rwb = 1'b1;
        bus.req_burst = 1'b0;
        bus.req_adr = '0;
        bus.req_wdata = '0;
        bus.req_byteen = '0;
        step(); step(); step();
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
        chk("rst_mem_oe", 32'(bus.mem_oe), 32'd0);
        chk("rst_mem_rwb", 32'(bus.mem_rwb), 32'd1);
        chk("rst_mem_byteen", 32'(bus.mem_byteen), 32'd0);
        chk("rst_mem_adr", 32'(bus.mem_adr), 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) apply_vec(i);

        // Three wait cycles, then done: outputs held, one clean response.
        r_fixed = 32'd0;
        r_done  = 1'b0;
        issue(1'b1, 1'b0, 13'h0055, 32'h0, 4'h0);
        for (int k = 0; k < 4; k++) begin
            chk("ws_mem_en", 32'(bus.mem_en), 32'd1);
            chk("ws_mem_adr", 32'(bus.mem_adr), 32'h0055);
            chk("ws_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            if (k == 3) r_done = 1'b1;
            step();
        end
        r_done = 1'b0;
        chk("ws_rsp_valid_end", 32'(bus.rsp_valid), 32'd1);
        chk("ws_rsp_data", bus.rsp_data, 32'hA5A5_0055);
        chk("ws_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("ws_rsp_last", 32'(bus.rsp_last), 32'd1);
        step();
        chk("ws_after_valid", 32'(bus.rsp_valid), 32'd0);
        $display("txn wait-state read adr=0055");

        // Burst read with done never arriving: error after 255 wait cycles.
        issue(1'b1, 1'b1, 13'h0200, 32'h0, 4'h0);
        bad = 1'b0;
        for (int k = 1; k <= 255; k++) begin
            if (bus.rsp_valid !== 1'b0 || bus.mem_en !== 1'b1 || bus.mem_adr !== 13'h0200)
                bad = 1'b1;
            step();
        end
        chk("to_held_no_rsp", 32'(bad), 32'd0);
        chk("to_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("to_rsp_err", 32'(bus.rsp_err), 32'd1);
        chk("to_rsp_last", 32'(bus.rsp_last), 32'd1);
        chk("to_rsp_data", bus.rsp_data, 32'd0);
        chk("to_mem_en", 32'(bus.mem_en), 32'd0);
        chk("to_mem_rwb", 32'(bus.mem_rwb), 32'd1);
        step();
        chk("to_no_more_beats", 32'(bus.rsp_valid), 32'd0);
        $display("txn timeout burst adr=0200");

        // Done in the 255th wait cycle wins over the timeout.
        issue(1'b1, 1'b0, 13'h0077, 32'h0, 4'h0);
        for (int k = 1; k <= 255; k++) begin
            if (k == 255) r_done = 1'b1;
            step();
        end
        r_done = 1'b0;
        chk("dw_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("dw_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("dw_rsp_data", bus.rsp_data, 32'hA5A5_0077);
        $display("txn done-wins read adr=0077");

        // Reset after the first burst beat drops the rest silently.
        r_done = 1'b1;
        issue(1'b1, 1'b1, 13'h0300, 32'h0, 4'h0);
        step();
        chk("mr_beat0_valid", 32'(bus.rsp_valid), 32'd1);
        chk("mr_beat0_last", 32'(bus.rsp_last), 32'd0);
        reset = 1'b1;
        step();
        chk("mr_mem_en", 32'(bus.mem_en), 32'd0);
        chk("mr_mem_rwb", 32'(bus.mem_rwb), 32'd1);
        chk("mr_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mr_rsp_last", 32'(bus.rsp_last), 32'd0);
        reset = 1'b0;
        $display("txn burst aborted by reset adr=0300");
        apply_vec(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/extmem_initiator.md
Name: extmem_initiator

Overview:
- CPU-side bus master for the external memory port: accepts single-word read/write and line-fill burst requests from the cache/control path.
- Drives the external memory address, data, byte-enable, rwb and en signals, and waits for done on every beat.
- Returns read data or write acknowledges with a timeout error path.
- Sits between the cache controllers and the external memory system; the external bidirectional data bus is split here into mem_wdata/mem_oe/mem_rdata and resolved at the chip top.

Parameters:
ADRW, 13, word-address width of the external memory port
LINE_WORDS, 4, beats per line-fill burst (power of two, >=2)
TIMEOUT, 255, max cycles in ACCESS without done before an error response (>=1, fits 8 bits)

Ports:
ph1  input  1  system clock (single clock, rising edge)
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request this cycle
req_rwb  input  1  1=read, 0=write
req_burst  input  1  1=line-fill burst (reads only; ignored for writes)
req_adr  input  ADRW  word address (critical word for bursts)
req_wdata  input  32  write data
req_byteen  input  4  write byte enables, bit0 = data[7:0]
rsp_valid  output  1  one-cycle response strobe per beat
rsp_data  output  32  read data (0 for write ack / error)
rsp_last  output  1  final beat of the transaction
rsp_err  output  1  transaction aborted by timeout
mem_adr  output  ADRW  memory word address
mem_wdata  output  32  write data to the bus
mem_oe  output  1  1 = this block drives the data bus
mem_rdata  input  32  data from the bus
mem_byteen  output  4  byte enables (0000 on reads)
mem_rwb  output  1  1=read, 0=write
mem_en  output  1  access enable
mem_done  input  1  access complete

Behaviour:
- Reset (synchronous, takes effect at the ph1 edge with reset=1): state IDLE; req_ready=1 only after reset deasserts; rsp_valid/rsp_last/rsp_err=0; rsp_data=0; mem_en=0; mem_oe=0; mem_rwb=1; mem_byteen=0; mem_adr=0; mem_wdata=0. Any in-flight transaction is dropped with no response.
- All outputs are registered. req_ready=1 exactly in IDLE.
- States:
  - IDLE: on req_valid, latch the request, clear beat/wait counters, and go to ACCESS.
  - ACCESS: mem_en=1 with mem_adr/mem_rwb/mem_byteen/mem_wdata held stable until done is sampled.
  - RECOVER: one cycle, mem_en=0, mem_oe=0, mem_rwb=1, then IDLE.
- Bus safety:
  - mem_rwb=0 and mem_oe=1 only while in a write ACCESS; in every other cycle mem_rwb=1 and mem_oe=0, because the memory writes whenever rwb is low.
  - Write-to-read turnaround is guaranteed by RECOVER.
- ACCESS, done=1 sampled at a ph1 edge:
  - Next cycle: rsp_valid=1 for one cycle. Reads return rsp_data=mem_rdata captured at that edge; writes return rsp_data=0.
  - On the last beat (single access, or beat LINE_WORDS-1): rsp_last=1 and go to RECOVER.
  - Otherwise: beat+1 and remain in ACCESS with the new address; wait counter cleared.
- Burst addressing is critical-word-first with wrap within the aligned line. mem_adr = {req_adr[ADRW-1:log2L], (req_adr[log2L-1:0]+beat) mod LINE_WORDS}.
- Timing with done tied high:
  - Single access: accept edge at cycle 0; ACCESS in cycle 1; rsp_valid in cycle 2 with RECOVER; req_ready=1 in cycle 3.
  - Burst of 4: ACCESS in cycles 1-4; rsp_valid in cycles 2-5; rsp_last in cycle 5; IDLE in cycle 6.
- Wait states: each ACCESS cycle without done increments the wait counter; outputs are held.
- Timeout: when the wait counter reaches TIMEOUT without done, the next cycle gives rsp_valid=1, rsp_err=1, rsp_last=1, rsp_data=0. Remaining burst beats are abandoned; go to RECOVER. Beats already returned stay valid.
- A done arriving in the same cycle the counter hits TIMEOUT counts as success; done wins.
- req_valid is ignored outside IDLE. req_burst=1 with req_rwb=0 is performed as a single write.

Test Plan:
- Reset, then single read adr=0x0010, mem_rdata=0xDEADBEEF, done=1 -> mem_en high 1 cycle with mem_rwb=1, mem_byteen=0; rsp_valid+rsp_last with 0xDEADBEEF 2 cycles after accept; req_ready back 3 cycles after accept.
- Write adr=0x0004, wdata=0x12345678, byteen=0101 -> one ACCESS cycle with mem_rwb=0, mem_oe=1, mem_byteen=0101; ack rsp_data=0, rsp_last=1; mem_rwb=1 and mem_oe=0 in RECOVER.
- Burst read req_adr=0x0102, LINE_WORDS=4 -> mem_adr sequence 0x102, 0x103, 0x100, 0x101; 4 rsp_valid beats with rsp_last only on the 4th.
- Read with done held low 3 cycles then high -> outputs stable for 4 ACCESS cycles; single correct response; no error.
- done held low, TIMEOUT=255, burst read -> rsp_err=1, rsp_last=1 after 255 wait cycles; RECOVER; no further beats.
- Reset asserted mid-burst after beat 1 -> next cycle mem_en=0, mem_rwb=1, rsp_valid=0; no rsp_last; a new request is accepted normally after reset deasserts.
